pipe_scroller: RTL and testbench

//   Consumes the 3-bit LFSR pattern and builds the scrolling pipe field for the 16x16 LED display.
//   On each scroll tick it shifts the field one column left.

---
 rtl/flappy_pkg.sv | 17 +
 rtl/pipe_column_gen.sv | 20 ++
 rtl/pipe_scroller.sv | 70 +++++++
 tb/tb_pipe_scroller.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/flappy_pkg.sv
// Shared types and geometry for the scrolling pipe field.
package flappy_pkg;

  localparam int unsigned ROWS     = 16;
  localparam int unsigned COLS     = 16;
  localparam int unsigned GAP      = 4;
  localparam int unsigned OFFSET   = 2;
  localparam int unsigned SPACING  = 6;
  localparam int unsigned BIRD_COL = 3;
  localparam int unsigned PAT_W    = 3;
  localparam int unsigned CNT_W    = $clog2(SPACING);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} scroll_state_t;

  typedef logic [ROWS-1:0] column_t;

endpackage

// File: rtl/pipe_column_gen.sv
// Builds one pipe column: all rows lit except a GAP-row opening placed by the pattern.
module pipe_column_gen #(
  parameter int unsigned ROWS   = 16,
  parameter int unsigned GAP    = 4,
  parameter int unsigned OFFSET = 2
) (
  input  logic [2:0]      pattern,
  output logic [ROWS-1:0] column_c
);

  localparam logic [ROWS-1:0] GAP_MASK = ROWS'((1 << GAP) - 1);

  int unsigned gap_lo;

  always_comb begin
    gap_lo   = OFFSET + 32'(pattern);
    column_c = ~(GAP_MASK << gap_lo);
  end

endmodule

// File: rtl/pipe_scroller.sv
// Scroll FSM, pipe spacing counter, field shift register and bird-column pass detect.
module pipe_scroller
  import flappy_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       start,
  input  logic                       crash,
  input  logic                       tick,
  input  logic [PAT_W-1:0]           pattern,
  output logic                       lfsr_en,
  output logic [COLS-1:0][ROWS-1:0]  field,
  output logic                       pipe_pass,
  output logic                       running
);

  scroll_state_t    state, state_nxt;
  logic [CNT_W-1:0] space_cnt;
  column_t          pipe_col;
  column_t          new_col;
  logic             enter_run;
  logic             advance;

  pipe_column_gen #(
    .ROWS  (ROWS),
    .GAP   (GAP),
    .OFFSET(OFFSET)
  ) u_col_gen (
    .pattern (pattern),
    .column_c(pipe_col)
  );

  // crash outranks tick; start is only honoured outside RUN
  assign enter_run = (state != S_RUN) && start;
  assign advance   = (state == S_RUN) && tick && !crash;
  assign lfsr_en   = advance && (space_cnt == '0);
  assign new_col   = (space_cnt == '0) ? pipe_col : '0;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (crash) state_nxt = S_HALT;
      S_HALT:  if (start) state_nxt = S_RUN;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      running   <= 1'b0;
      field     <= '0;
      space_cnt <= '0;
      pipe_pass <= 1'b0;
    end else begin
      state     <= state_nxt;
      running   <= (state_nxt == S_RUN);
      pipe_pass <= advance && (|field[BIRD_COL]);
      if (enter_run) begin
        field     <= '0;
        space_cnt <= '0;
      end else if (advance) begin
        field     <= {new_col, field[COLS-1:1]};
        space_cnt <= (space_cnt == CNT_W'(SPACING - 1)) ? '0 : space_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipe_scroller.sv
// Randomised and directed checks of pipe_scroller against a tick-history model.
module tb_pipe_scroller;

  localparam int ROWS     = 16;
  localparam int COLS     = 16;
  localparam int SPACING  = 6;
  localparam int BIRD_COL = 3;

  logic                      clk = 1'b0;
  logic                      reset_n = 1'b0;
  logic                      start = 1'b0;
  logic                      crash = 1'b0;
  logic                      tick = 1'b0;
  logic [2:0]                pattern = 3'd0;
  logic                      lfsr_en;
  logic [COLS-1:0][ROWS-1:0] field;
  logic                      pipe_pass;
  logic                      running;

  int n_checks = 0;
  int n_fail   = 0;
  bit check_en = 1'b0;

  // model: run state, ticks taken this run, and the pattern used by each inserting tick
  int m_state = 0;   // 0 idle, 1 run, 2 halt
  int m_n     = 0;
  bit m_pass  = 1'b0;
  int pat_hist [int];

  pipe_scroller dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .crash    (crash),
    .tick     (tick),
    .pattern  (pattern),
    .lfsr_en  (lfsr_en),
    .field    (field),
    .pipe_pass(pipe_pass),
    .running  (running)
  );

  always #5 clk = ~clk;

  function automatic logic [ROWS-1:0] pipe_of(input int p);
    logic [ROWS-1:0] m;
    m = '1;
    for (int r = 0; r < 4; r++) m[4'(2 + p + r)] = 1'b0;
    return m;
  endfunction

  // a tick k (1-based within the run) inserts a pipe when (k-1) is a multiple of SPACING
  function automatic bit is_pipe_tick(input int k);
    return (k >= 1) && (((k - 1) % SPACING) == 0);
  endfunction

  function automatic logic [ROWS-1:0] exp_col(input int c);
    int k;
    k = m_n - (COLS - 1 - c);
    if (is_pipe_tick(k)) return pipe_of(pat_hist[k]);
    return '0;
  endfunction

  task automatic check(input string name, input logic [ROWS-1:0] act, input logic [ROWS-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_state = 0;
      m_n     = 0;
      m_pass  = 1'b0;
    end else begin
      m_pass = 1'b0;
      if (m_state != 1 && start) begin
        m_state = 1;
        m_n     = 0;
      end else if (m_state == 1 && crash) begin
        m_state = 2;
      end else if (m_state == 1 && tick) begin
        m_pass = is_pipe_tick(m_n - (COLS - 1 - BIRD_COL));
        m_n++;
        if (is_pipe_tick(m_n)) pat_hist[m_n] = int'(pattern);
      end
    end
  end

  // every cycle: all outputs against the model
  always @(negedge clk) begin
    #1;
    if (check_en) begin
      logic exp_lfsr;
      bit   fok;
      exp_lfsr = (m_state == 1) && tick && !crash && ((m_n % SPACING) == 0);
      fok = 1'b1;
      for (int c = 0; c < COLS; c++)
        if (field[4'(c)] !== exp_col(c)) begin
          fok = 1'b0;
          $display("FAIL field col %0d: got %h expected %h at %0t", c, field[4'(c)], exp_col(c), $time);
        end
      n_checks++;
      if (!fok) n_fail++;
      check("running", 16'(running), 16'(m_state == 1));
      check("pipe_pass", 16'(pipe_pass), 16'(m_pass));
      check("lfsr_en", 16'(lfsr_en), 16'(exp_lfsr));
    end
  end

  task automatic cyc(input logic s, input logic c, input logic t, input logic [2:0] p);
    @(negedge clk);
    start = s; crash = c; tick = t; pattern = p;
  endtask

  task automatic settle();
    @(negedge clk);
    start = 1'b0; crash = 1'b0; tick = 1'b0;
    #2;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    #2;
    check("reset field3", field[3], 16'h0);
    check("reset running", 16'(running), 16'h0);
    check_en = 1'b1;

    // first insertion, pattern 0
    cyc(1, 0, 0, 3'd0);
    cyc(0, 0, 1, 3'd0);
    settle();
    check("pat0 col15", field[15], 16'hFFC3);
    for (int i = 2; i <= 6; i++) cyc(0, 0, 1, 3'($urandom_range(0, 7)));
    cyc(0, 0, 1, 3'd7);
    settle();
    check("pat7 col15", field[15], 16'hE1FF);
    for (int i = 8; i <= 12; i++) cyc(0, 0, 1, 3'($urandom_range(0, 7)));
    cyc(0, 0, 1, 3'd5);
    settle();
    check("13 ticks col3", field[3], 16'hFFC3);
    check("13 ticks col9", field[9], 16'hE1FF);
    check("13 ticks col15", field[15], 16'hF87F);
    check("13 ticks col4", field[4], 16'h0);
    cyc(0, 0, 1, 3'd2);
    settle();
    check("tick14 pass", 16'(pipe_pass), 16'h1);
    check("tick14 col2", field[2], 16'hFFC3);

    // crash together with tick freezes the frame
    cyc(0, 1, 1, 3'd1);
    settle();
    check("crash running", 16'(running), 16'h0);
    check("crash col2", field[2], 16'hFFC3);
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, 3'($urandom_range(0, 7)));
    settle();
    check("halt col2", field[2], 16'hFFC3);
    cyc(1, 1, 0, 3'd0);
    settle();
    check("restart running", 16'(running), 16'h1);
    check("restart col2", field[2], 16'h0);

    // random traffic
    for (int i = 0; i < 3000; i++)
      cyc(logic'($urandom_range(0, 99) < 2), logic'($urandom_range(0, 99) < 3),
          logic'($urandom_range(0, 99) < 35), 3'($urandom_range(0, 7)));
    settle();

    // asynchronous reset between edges, mid-run with a pending insertion tick
    cyc(1, 0, 0, 3'd0);
    cyc(0, 0, 1, 3'd4);
    cyc(0, 0, 1, 3'd3);
    #3;
    reset_n = 1'b0;
    #1;
    check("areset col15", field[15], 16'h0);
    check("areset running", 16'(running), 16'h0);
    check("areset lfsr_en", 16'(lfsr_en), 16'h0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 12; i++) cyc(0, 0, 1, 3'($urandom_range(0, 7)));
    settle();
    check("idle ticks col15", field[15], 16'h0);
    check("idle ticks running", 16'(running), 16'h0);

    check_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
